// File: rtl/cdm_sweep_pkg.sv
// Shared state encoding and width helpers for the carry-disregard multiplier sweep controller.
package cdm_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned W_DEFAULT = 8;
    localparam int unsigned SUM_GUARD = 16;

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned w);
        return 2 * w + 1;
    endfunction

    function automatic int unsigned sum_w(input int unsigned w);
        return 2 * w + SUM_GUARD;
    endfunction

endpackage

// File: rtl/cdm_err_accum.sv
// Two-stage error accumulator: registers one result/exact pair, then folds |approx - exact| into the metrics.
module cdm_err_accum
    import cdm_sweep_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     valid,
    input  logic [2*W-1:0]           approx,
    input  logic [2*W-1:0]           exact,
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    output logic [2*W:0]             err_count,
    output logic [2*W+SUM_GUARD-1:0] sum_abs_err,
    output logic [2*W-1:0]           max_err,
    output logic [W-1:0]             max_err_a,
    output logic [W-1:0]             max_err_b
);

    localparam int unsigned PW = prod_w(W);
    localparam int unsigned CW = cnt_w(W);
    localparam int unsigned SW = sum_w(W);

    logic [PW-1:0] approx_q;
    logic [PW-1:0] exact_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          valid_q;
    logic [PW-1:0] err_c;

    // Stage 1: capture one pair per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            approx_q <= '0;
            exact_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            approx_q <= approx;
            exact_q  <= exact;
            a_q      <= a;
            b_q      <= b;
            valid_q  <= valid & ~clear;
        end
    end

    always_comb begin
        err_c = '0;
        if (approx_q >= exact_q) begin
            err_c = approx_q - exact_q;
        end else begin
            err_c = exact_q - approx_q;
        end
    end

    // Stage 2: strict greater-than keeps the earliest pair on a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_err     <= '0;
            max_err_a   <= '0;
            max_err_b   <= '0;
        end else if (clear) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_err     <= '0;
            max_err_a   <= '0;
            max_err_b   <= '0;
        end else if (valid_q) begin
            if (err_c != '0) begin
                err_count <= err_count + CW'(1);
            end
            sum_abs_err <= sum_abs_err + SW'(err_c);
            if (err_c > max_err) begin
                max_err   <= err_c;
                max_err_a <= a_q;
                max_err_b <= b_q;
            end
        end
    end

endmodule

// File: rtl/cdm_sweep_ctrl.sv
// Sweeps an attached WxW multiplier over every operand pair and accumulates error metrics against the exact product.
module cdm_sweep_ctrl
    import cdm_sweep_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [W-1:0]             mul_a,
    output logic [W-1:0]             mul_b,
    input  logic [2*W-1:0]           mul_r,
    output logic                     busy,
    output logic                     done,
    output logic [2*W:0]             err_count,
    output logic [2*W+SUM_GUARD-1:0] sum_abs_err,
    output logic [2*W-1:0]           max_err,
    output logic [W-1:0]             max_err_a,
    output logic [W-1:0]             max_err_b
);

    localparam int unsigned PW = prod_w(W);

    state_t        state_q;
    state_t        state_d;
    logic          accept_c;
    logic          last_pair_c;
    logic [PW-1:0] exact_c;

    assign last_pair_c = &{mul_a, mul_b};
    assign exact_c     = PW'(mul_a) * PW'(mul_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == RUN) || (state_d == DRAIN);
            done    <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    accept_c = 1'b1;
                end
            end
            RUN: begin
                if (last_pair_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Pair counter: b is the low half, so it wraps into a; holds on the final pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept_c) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if ((state_q == RUN) && !last_pair_c) begin
            {mul_a, mul_b} <= {mul_a, mul_b} + PW'(1);
        end
    end

    cdm_err_accum #(
        .W (W)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clear       (accept_c),
        .valid       (state_q == RUN),
        .approx      (mul_r),
        .exact       (exact_c),
        .a           (mul_a),
        .b           (mul_b),
        .err_count   (err_count),
        .sum_abs_err (sum_abs_err),
        .max_err     (max_err),
        .max_err_a   (max_err_a),
        .max_err_b   (max_err_b)
    );

endmodule

// File: tb/tb_cdm_sweep_ctrl.sv
// Directed bench: one full 8-bit sweep plus several 4-bit sweeps against stub multipliers with hand-derived metrics.
module tb_cdm_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start8, busy8, done8;
    logic [7:0]  mul_a8, mul_b8, max_err_a8, max_err_b8;
    logic [15:0] mul_r8, max_err8;
    logic [16:0] err_count8;
    logic [31:0] sum8;
    int          mode8;

    logic        start4, busy4, done4;
    logic [3:0]  mul_a4, mul_b4, max_err_a4, max_err_b4;
    logic [7:0]  mul_r4, max_err4;
    logic [8:0]  err_count4;
    logic [23:0] sum4;
    int          mode4;

    int checks = 0;
    int errors = 0;

    cdm_sweep_ctrl #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .mul_a(mul_a8), .mul_b(mul_b8), .mul_r(mul_r8),
        .busy(busy8), .done(done8), .err_count(err_count8), .sum_abs_err(sum8),
        .max_err(max_err8), .max_err_a(max_err_a8), .max_err_b(max_err_b8)
    );

    cdm_sweep_ctrl #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .mul_a(mul_a4), .mul_b(mul_b4), .mul_r(mul_r4),
        .busy(busy4), .done(done4), .err_count(err_count4), .sum_abs_err(sum4),
        .max_err(max_err4), .max_err_a(max_err_a4), .max_err_b(max_err_b4)
    );

    // Stub multipliers: 0 exact, 1 bit0 cleared, 2 zero only at max pair, 3 always zero, 4 exact+1.
    always_comb begin
        logic [15:0] p;
        p = 16'(mul_a8) * 16'(mul_b8);
        case (mode8)
            1:       mul_r8 = p & 16'hFFFE;
            2:       mul_r8 = (mul_a8 == 8'hFF && mul_b8 == 8'hFF) ? 16'd0 : p;
            3:       mul_r8 = 16'd0;
            4:       mul_r8 = p + 16'd1;
            default: mul_r8 = p;
        endcase
    end

    always_comb begin
        logic [7:0] p;
        p = 8'(mul_a4) * 8'(mul_b4);
        case (mode4)
            1:       mul_r4 = p & 8'hFE;
            2:       mul_r4 = (mul_a4 == 4'hF && mul_b4 == 4'hF) ? 8'd0 : p;
            3:       mul_r4 = 8'd0;
            4:       mul_r4 = p + 8'd1;
            default: mul_r4 = p;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses start4 into edge 0, snapshots outputs just after it, then counts edges until done.
    task automatic sweep4(output int lat, output logic bz, output logic dn,
                          output logic [63:0] e0, output logic [63:0] s0, output logic [63:0] m0);
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        bz = busy4;
        dn = done4;
        e0 = 64'(err_count4);
        s0 = 64'(sum4);
        m0 = 64'(max_err4);
        lat = 0;
        while (!done4 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check4(input string tag, input int lat, input int e, input int s,
                          input int m, input int ma, input int mb);
        check({tag, " latency"}, 64'(lat), 64'(257));
        check({tag, " err_count"}, 64'(err_count4), 64'(e));
        check({tag, " sum_abs_err"}, 64'(sum4), 64'(s));
        check({tag, " max_err"}, 64'(max_err4), 64'(m));
        check({tag, " max_err_a"}, 64'(max_err_a4), 64'(ma));
        check({tag, " max_err_b"}, 64'(max_err_b4), 64'(mb));
        check({tag, " busy"}, 64'(busy4), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        logic bz, dn;
        logic [63:0] e0, s0, m0;

        rst = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        mode8 = 1;
        mode4 = 2;
        repeat (3) @(posedge clk);
        #1;
        check("reset mul_a8", 64'(mul_a8), 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset done8", 64'(done8), 64'd0);
        check("reset err_count8", 64'(err_count8), 64'd0);
        check("reset mul_b4", 64'(mul_b4), 64'd0);
        check("reset max_err4", 64'(max_err4), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full 8-bit sweep with bit 0 cleared, start pulses mid-sweep must be ignored.
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("w8 busy at accept", 64'(busy8), 64'd1);
        check("w8 pair0 mul_b", 64'(mul_b8), 64'd0);
        lat = 0;
        while (!done8 && lat < 70000) begin
            start8 = (lat == 10 || lat == 40000);
            @(posedge clk);
            #1;
            lat++;
        end
        start8 = 1'b0;
        check("w8 latency", 64'(lat), 64'd65537);
        check("w8 err_count", 64'(err_count8), 64'd16384);
        check("w8 sum_abs_err", 64'(sum8), 64'd16384);
        check("w8 max_err", 64'(max_err8), 64'd1);
        check("w8 max_err_a", 64'(max_err_a8), 64'd1);
        check("w8 max_err_b", 64'(max_err_b8), 64'd1);
        check("w8 busy", 64'(busy8), 64'd0);
        check("w8 mul_a hold", 64'(mul_a8), 64'd255);
        check("w8 mul_b hold", 64'(mul_b8), 64'd255);

        mode4 = 2;
        sweep4(lat, bz, dn, e0, s0, m0);
        check4("w4 max-pair zero", lat, 1, 225, 225, 15, 15);

        mode4 = 3;
        sweep4(lat, bz, dn, e0, s0, m0);
        check4("w4 zero", lat, 225, 14400, 225, 15, 15);

        // Restart from DONE: metrics clear at the accept edge, results repeat.
        sweep4(lat, bz, dn, e0, s0, m0);
        check("restart busy at accept", 64'(bz), 64'd1);
        check("restart done at accept", 64'(dn), 64'd0);
        check("restart err_count at accept", e0, 64'd0);
        check("restart sum at accept", s0, 64'd0);
        check("restart max_err at accept", m0, 64'd0);
        check4("w4 zero repeat", lat, 225, 14400, 225, 15, 15);

        mode4 = 0;
        sweep4(lat, bz, dn, e0, s0, m0);
        check4("w4 exact", lat, 0, 0, 0, 0, 0);

        mode4 = 1;
        sweep4(lat, bz, dn, e0, s0, m0);
        check4("w4 bit0", lat, 64, 64, 1, 1, 1);

        mode4 = 4;
        sweep4(lat, bz, dn, e0, s0, m0);
        check4("w4 plus1", lat, 256, 256, 1, 0, 0);

        // Reset while pair 100 (a=6, b=4) is presented aborts the sweep.
        mode4 = 3;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        n = 0;
        while (!(mul_a4 == 4'd6 && mul_b4 == 4'd4) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach pair 100", 64'(n), 64'd100);
        rst = 1'b1;
        #1;
        check("abort mul_a4", 64'(mul_a4), 64'd0);
        check("abort mul_b4", 64'(mul_b4), 64'd0);
        check("abort busy4", 64'(busy4), 64'd0);
        check("abort err_count4", 64'(err_count4), 64'd0);
        check("abort sum4", 64'(sum4), 64'd0);
        check("abort done8", 64'(done8), 64'd0);
        check("abort err_count8", 64'(err_count8), 64'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle after abort busy4", 64'(busy4), 64'd0);
        check("idle after abort done4", 64'(done4), 64'd0);

        sweep4(lat, bz, dn, e0, s0, m0);
        check4("w4 after abort", lat, 225, 14400, 225, 15, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
